// File: rtl/ascon_output_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascon_pack (package)
// Purpose  : Shared constants, FSM state encodings and helpers for the
//            Ascon-AEAD128 datapath output stage.
// Contents : BLOCK_WIDTH / BLOCK_BYTES / CNT_W, serializer state codes,
//            byte_cnt_clamp().
// Revision : 1.0 - initial release
// ============================================================================
package ascon_pack;

    localparam int unsigned BLOCK_WIDTH = 128;
    localparam int unsigned BLOCK_BYTES = BLOCK_WIDTH / 8;
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1);

    // Output serializer state encoding
    localparam int unsigned        STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_SEND = 1'b1;

    // Effective byte count of a block: non-final blocks are always full,
    // final blocks are clamped to the block size. The result always fits in
    // CNT_W bits of the instantiating module; max_bytes lets a module with
    // a non-default block width reuse the helper.
    function automatic int unsigned byte_cnt_clamp(
        input int unsigned count,
        input logic        is_last,
        input int unsigned max_bytes = BLOCK_BYTES
    );
        if (!is_last) begin
            return max_bytes;
        end
        return (count > max_bytes) ? max_bytes : count;
    endfunction

endpackage : ascon_pack
`default_nettype wire

// File: rtl/ascon_byte_mask.sv
`default_nettype none
// ============================================================================
// Module   : ascon_byte_mask
// Purpose  : Combinational byte-strobe / zeroing-mask generator for one
//            output word of a (possibly truncated) block.
// Ports    : word_idx_i  - index of the word within the block
//            byte_cnt_i  - number of valid bytes in the block
//            strb_o      - per-byte valid flags of the word
//            mask_o      - bit mask (0xFF for valid bytes, 0x00 otherwise)
// Revision : 1.0 - initial release
// ============================================================================
module ascon_byte_mask #(
    parameter  int unsigned BLOCK_WIDTH = 128,
    parameter  int unsigned OUT_WIDTH   = 32,
    localparam int unsigned WORDS       = BLOCK_WIDTH / OUT_WIDTH,
    localparam int unsigned OUT_BYTES   = OUT_WIDTH / 8,
    localparam int unsigned BLOCK_BYTES = BLOCK_WIDTH / 8,
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1),
    localparam int unsigned IDX_W       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic [IDX_W-1:0]     word_idx_i,
    input  logic [CNT_W-1:0]     byte_cnt_i,
    output logic [OUT_BYTES-1:0] strb_o,
    output logic [OUT_WIDTH-1:0] mask_o
);

    for (genvar j = 0; j < OUT_BYTES; j++) begin : g_byte
        // Absolute byte position within the block compared to the count
        assign strb_o[j]        = (32'(word_idx_i) * OUT_BYTES + 32'(j)) < 32'(byte_cnt_i);
        assign mask_o[8*j +: 8] = {8{strb_o[j]}};
    end

endmodule : ascon_byte_mask
`default_nettype wire

// File: rtl/ascon_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ascon_output_serializer
// Purpose  : Registered, back-pressurable output stage. Accepts one block
//            per handshake and streams it as OUT_WIDTH-bit words with byte
//            strobes; final blocks are truncated to their valid byte count.
// Ports    : clk_i, rst_i (async, active-high), flush_i (sync abort)
//            in_valid_i / in_ready_o / in_data_i / in_last_i / in_bytes_i
//            out_valid_o / out_ready_i / out_data_o / out_strb_o / out_last_o
// Revision : 1.0 - initial release
// ============================================================================
module ascon_output_serializer #(
    parameter  int unsigned BLOCK_WIDTH = ascon_pack::BLOCK_WIDTH,
    parameter  int unsigned OUT_WIDTH   = 32,
    localparam int unsigned WORDS       = BLOCK_WIDTH / OUT_WIDTH,
    localparam int unsigned OUT_BYTES   = OUT_WIDTH / 8,
    localparam int unsigned BLOCK_BYTES = BLOCK_WIDTH / 8,
    localparam int unsigned CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [BLOCK_WIDTH-1:0] in_data_i,
    input  logic                   in_last_i,
    input  logic [CNT_W-1:0]       in_bytes_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_WIDTH-1:0]   out_data_o,
    output logic [OUT_BYTES-1:0]   out_strb_o,
    output logic                   out_last_o
);
    import ascon_pack::*;

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    if ((OUT_WIDTH % 8 != 0) || (BLOCK_WIDTH % OUT_WIDTH != 0)) begin : g_param_check
        $error("ascon_output_serializer: OUT_WIDTH must be a multiple of 8 dividing BLOCK_WIDTH");
    end

    // Index of the final word for a block holding nbytes valid bytes.
    // A zero-byte block still emits one (empty) word.
    function automatic logic [IDX_W-1:0] last_word_idx(input logic [CNT_W-1:0] nbytes);
        if (nbytes == '0) begin
            return '0;
        end
        return IDX_W'((32'(nbytes) - 32'd1) / OUT_BYTES);
    endfunction

    // ------------------------------------------------------------------
    // State and held block
    // ------------------------------------------------------------------
    logic [STATE_W-1:0]   state_q, state_d;
    logic                 last_q;
    logic [CNT_W-1:0]     bytes_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_idx_q;
    logic [BLOCK_WIDTH-1:0] blk_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic [OUT_BYTES-1:0] out_strb_q;
    logic                 out_last_q;

    // ------------------------------------------------------------------
    // Handshake / control
    // ------------------------------------------------------------------
    logic w_final;
    logic w_out_hs;
    logic w_cap;

    // Next word source: a freshly captured block starts at word 0,
    // otherwise the held block advances by one word.
    logic [BLOCK_WIDTH-1:0] w_load_blk;
    logic [CNT_W-1:0]       w_load_bytes;
    logic [CNT_W-1:0]       w_in_bytes;
    logic [IDX_W-1:0]       w_load_idx;
    logic [IDX_W-1:0]       w_load_last_idx;
    logic                   w_load_last_flag;
    logic [OUT_BYTES-1:0]   w_strb;
    logic [OUT_WIDTH-1:0]   w_mask;
    logic [OUT_WIDTH-1:0]   w_word;

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cap) begin
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_out_hs && w_final) begin
                        state_d = w_cap ? ST_SEND : ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs / handshake decode. in_ready_o depends on out_ready_i
    // combinationally so a new block can load on the final-word handshake.
    always_comb begin
        w_final    = (idx_q == last_idx_q);
        w_out_hs   = (state_q == ST_SEND) && out_ready_i;
        in_ready_o = !flush_i && ((state_q == ST_IDLE) || (w_final && out_ready_i));
    end

    assign w_cap = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Next-word selection
    // ------------------------------------------------------------------
    always_comb begin
        w_in_bytes = CNT_W'(byte_cnt_clamp(32'(in_bytes_i), in_last_i, BLOCK_BYTES));
        if (w_cap) begin
            w_load_blk       = in_data_i;
            w_load_bytes     = w_in_bytes;
            w_load_idx       = '0;
            w_load_last_flag = in_last_i;
            w_load_last_idx  = last_word_idx(w_in_bytes);
        end else begin
            w_load_blk       = blk_q;
            w_load_bytes     = bytes_q;
            w_load_idx       = idx_q + 1'b1;
            w_load_last_flag = last_q;
            w_load_last_idx  = last_idx_q;
        end
    end

    ascon_byte_mask #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_byte_mask (
        .word_idx_i (w_load_idx),
        .byte_cnt_i (w_load_bytes),
        .strb_o     (w_strb),
        .mask_o     (w_mask)
    );

    assign w_word = OUT_WIDTH'(w_load_blk >> (32'(w_load_idx) * OUT_WIDTH)) & w_mask;

    // ------------------------------------------------------------------
    // Block register, word counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_q      <= '0;
            last_q     <= 1'b0;
            bytes_q    <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            out_data_q <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
        end else if (flush_i) begin
            idx_q      <= '0;
            out_data_q <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
        end else if (w_cap || (w_out_hs && !w_final)) begin
            if (w_cap) begin
                blk_q      <= in_data_i;
                last_q     <= in_last_i;
                bytes_q    <= w_in_bytes;
                last_idx_q <= w_load_last_idx;
            end
            idx_q      <= w_load_idx;
            out_data_q <= w_word;
            out_strb_q <= w_strb;
            out_last_q <= w_load_last_flag && (w_load_idx == w_load_last_idx);
        end else if (w_out_hs) begin
            // Final word consumed with nothing new: counter wraps
            idx_q <= '0;
        end
    end

    assign out_valid_o = (state_q == ST_SEND);
    assign out_data_o  = out_data_q;
    assign out_strb_o  = out_strb_q;
    assign out_last_o  = out_last_q;

endmodule : ascon_output_serializer
`default_nettype wire

// File: tb/tb_ascon_output_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ascon_output_serializer
// Purpose  : Self-checking directed bench for ascon_output_serializer
//            (BLOCK_WIDTH=128, OUT_WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_output_serializer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         in_last_i;
    logic [4:0]   in_bytes_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [31:0]  out_data_o;
    logic [3:0]   out_strb_o;
    logic         out_last_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] eq_data[$];
    logic [3:0]  eq_strb[$];
    logic        eq_last[$];
    int          exp_total;

    logic [127:0] sd[3];
    logic         sl[3];
    logic [4:0]   sb[3];

    localparam logic [127:0] D  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] D2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

    ascon_output_serializer #(
        .BLOCK_WIDTH (128),
        .OUT_WIDTH   (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_bytes_i  (in_bytes_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one block for exactly one edge (called at a negedge, ready=1)
    task automatic push(input logic [127:0] d, input logic l, input logic [4:0] b);
        check("push_in_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        in_bytes_i = b;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_last_i  = 1'b0;
        in_bytes_i = '0;
    endtask

    // Check the currently presented word, then advance one cycle
    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
        check({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        check({tag, "_data"},  64'(out_data_o),  64'(d));
        check({tag, "_strb"},  64'(out_strb_o),  64'(s));
        check({tag, "_last"},  64'(out_last_o),  64'(l));
        @(negedge clk_i);
    endtask

    // Reference model: expected word stream of one block
    task automatic model_block(input logic [127:0] d, input logic l, input int unsigned b_in);
        int unsigned b;
        int unsigned n;
        logic [31:0] w;
        logic [3:0]  s;
        b = l ? ((b_in > 16) ? 16 : b_in) : 16;
        n = l ? ((b == 0) ? 1 : (b + 3) / 4) : 4;
        for (int k = 0; k < int'(n); k++) begin
            w = '0;
            s = '0;
            for (int j = 0; j < 4; j++) begin
                if (k * 4 + j < int'(b)) begin
                    w[8*j +: 8] = d[8*(k*4+j) +: 8];
                    s[j]        = 1'b1;
                end
            end
            eq_data.push_back(w);
            eq_strb.push_back(s);
            eq_last.push_back(l && (k == int'(n) - 1));
        end
        exp_total += int'(n);
    endtask

    // Stream three blocks back-to-back, optionally with random stalls
    task automatic run_stream(input string tag, input bit rnd);
        int          sent = 0;
        int          consumed = 0;
        int          first_cyc = -1;
        int          last_cyc = -1;
        bit          stalled = 1'b0;
        bit          done = 1'b0;
        logic [36:0] prev = '0;
        eq_data.delete();
        eq_strb.delete();
        eq_last.delete();
        exp_total = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (sent == 3 && eq_data.size() == 0) begin
                done = 1'b1;
                check({tag, "_idle_after"}, 64'(out_valid_o), 64'd0);
                break;
            end
            if (stalled) begin
                check({tag, "_hold"}, 64'({out_valid_o, out_last_o, out_strb_o, out_data_o}), 64'({1'b1, prev}));
            end
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid_o && out_ready_i) begin
                if (eq_data.size() == 0) begin
                    check({tag, "_extra_word"}, 64'd1, 64'd0);
                end else begin
                    check({tag, "_word"},
                          64'({out_last_o, out_strb_o, out_data_o}),
                          64'({eq_last.pop_front(), eq_strb.pop_front(), eq_data.pop_front()}));
                end
                consumed++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            stalled = out_valid_o && !out_ready_i;
            prev    = {out_last_o, out_strb_o, out_data_o};
            if (sent < 3) begin
                in_valid_i = 1'b1;
                in_data_i  = sd[sent];
                in_last_i  = sl[sent];
                in_bytes_i = sb[sent];
                #1;
                if (in_ready_o) begin
                    model_block(sd[sent], sl[sent], int'(sb[sent]));
                    sent++;
                end
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        check({tag, "_completed"}, 64'(done), 64'd1);
        check({tag, "_count"}, 64'(consumed), 64'(exp_total));
        if (!rnd) begin
            check({tag, "_nogap"}, 64'(last_cyc - first_cyc), 64'(exp_total - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        in_bytes_i  = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Reset state
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_data",  64'(out_data_o),  64'd0);
        check("rst_out_strb",  64'(out_strb_o),  64'd0);
        check("rst_out_last",  64'(out_last_o),  64'd0);
        check("rst_in_ready",  64'(in_ready_o),  64'd1);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Full block, first word one cycle after capture
        push(D, 1'b0, 5'd0);
        check("full_busy_ready", 64'(in_ready_o), 64'd0);
        expect_word("full_w0", 32'h03020100, 4'hF, 1'b0);
        expect_word("full_w1", 32'h07060504, 4'hF, 1'b0);
        expect_word("full_w2", 32'h0B0A0908, 4'hF, 1'b0);
        expect_word("full_w3", 32'h0F0E0D0C, 4'hF, 1'b0);
        check("full_idle", 64'(out_valid_o), 64'd0);

        // Last block, 5 bytes
        push(D, 1'b1, 5'd5);
        expect_word("b5_w0", 32'h03020100, 4'hF, 1'b0);
        expect_word("b5_w1", 32'h00000004, 4'h1, 1'b1);
        check("b5_idle", 64'(out_valid_o), 64'd0);

        // Last block, 0 bytes
        push(D, 1'b1, 5'd0);
        expect_word("b0_w0", 32'h00000000, 4'h0, 1'b1);
        check("b0_idle", 64'(out_valid_o), 64'd0);

        // Last block, 20 bytes clamped to 16
        push(D, 1'b1, 5'd20);
        expect_word("b20_w0", 32'h03020100, 4'hF, 1'b0);
        expect_word("b20_w1", 32'h07060504, 4'hF, 1'b0);
        expect_word("b20_w2", 32'h0B0A0908, 4'hF, 1'b0);
        expect_word("b20_w3", 32'h0F0E0D0C, 4'hF, 1'b1);
        check("b20_idle", 64'(out_valid_o), 64'd0);

        // Back-to-back streams
        sd[0] = 128'h1F1E1D1C_1B1A1918_17161514_13121110; sl[0] = 1'b0; sb[0] = 5'd0;
        sd[1] = 128'hA5A4A3A2_A1A0AFAE_ADACABAA_A9A8A7A6; sl[1] = 1'b0; sb[1] = 5'd3;
        sd[2] = 128'h5F5E5D5C_5B5A5958_57565554_53525150; sl[2] = 1'b1; sb[2] = 5'd7;
        run_stream("s_ready", 1'b0);
        run_stream("s_stall", 1'b1);
        @(negedge clk_i);

        // Flush after word 1; a block offered during flush is not captured
        push(D, 1'b0, 5'd0);
        expect_word("fl_w0", 32'h03020100, 4'hF, 1'b0);
        expect_word("fl_w1", 32'h07060504, 4'hF, 1'b0);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = D2;
        #1;
        check("fl_ready_during", 64'(in_ready_o), 64'd0);
        @(negedge clk_i);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        #1;
        check("fl_out_valid", 64'(out_valid_o), 64'd0);
        check("fl_in_ready",  64'(in_ready_o),  64'd1);
        @(negedge clk_i);
        push(D2, 1'b0, 5'd0);
        expect_word("fl_new_w0", 32'h33221100, 4'hF, 1'b0);
        expect_word("fl_new_w1", 32'h77665544, 4'hF, 1'b0);

        // Asynchronous reset mid-block
        repeat (3) @(negedge clk_i);
        push(D, 1'b0, 5'd0);
        expect_word("ar_w0", 32'h03020100, 4'hF, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid_o), 64'd0);
        check("ar_out_data",  64'(out_data_o),  64'd0);
        check("ar_out_strb",  64'(out_strb_o),  64'd0);
        check("ar_out_last",  64'(out_last_o),  64'd0);
        check("ar_in_ready",  64'(in_ready_o),  64'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        push(D2, 1'b1, 5'd6);
        expect_word("ar_new_w0", 32'h33221100, 4'hF, 1'b0);
        expect_word("ar_new_w1", 32'h00005544, 4'h3, 1'b1);
        check("ar_new_idle", 64'(out_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ascon_output_serializer
`default_nettype wire

// File: doc/ascon_output_serializer.md
# ascon_output_serializer

Registered output stage for the Ascon-AEAD128 datapath. It accepts one BLOCK_WIDTH-bit cipher/plaintext block per handshake and emits it as a stream of OUT_WIDTH-bit words with byte strobes. The final block of a message is truncated to its valid byte count, with unused bytes zeroed and strobes cleared. It sits between the permutation/XOR datapath and the subsystem's output bus interface and replaces purely combinational last-block truncation with a buffered, back-pressurable stage.

## Interface
Parameters:
- BLOCK_WIDTH, default ascon_pack::BLOCK_WIDTH (128): input block width in bits.
- OUT_WIDTH, default 32: output word width. Must be a multiple of 8 and must divide BLOCK_WIDTH; elaboration fails otherwise.
- Derived: WORDS = BLOCK_WIDTH/OUT_WIDTH, OUT_BYTES = OUT_WIDTH/8, BLOCK_BYTES = BLOCK_WIDTH/8, CNT_W = $clog2(BLOCK_BYTES+1).

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort; drops the held block.
- in_valid_i  in  1  input block valid.
- in_ready_o  out  1  stage can accept a block.
- in_data_i  in  BLOCK_WIDTH  block data; byte 0 at bits [7:0].
- in_last_i  in  1  block is the final block of the message.
- in_bytes_i  in  CNT_W  valid byte count. Used only when in_last_i=1.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  consumer accepts the word.
- out_data_o  out  OUT_WIDTH  output word.
- out_strb_o  out  OUT_BYTES  per-byte valid flags.
- out_last_o  out  1  final word of a final block.

## Operation
- States:
  - IDLE: empty.
  - SEND: block held, words pending.
- IDLE -> SEND when in_valid_i && in_ready_o. The block, last flag, and clamped byte count are captured.
- SEND -> IDLE when the final word handshakes and no new block is captured in the same cycle.
- SEND -> SEND (reload) when the final word handshakes and a new block is captured in the same cycle.
- in_ready_o = !flush_i && (state==IDLE || (final word && out_ready_i)). This gives a combinational path from out_ready_i, which is intentional and enables back-to-back blocks.
- Byte count:
  - Non-last block: byte count forced to BLOCK_BYTES.
  - Last block: byte count = min(in_bytes_i, BLOCK_BYTES).
- Word count n:
  - Non-last block: n = WORDS.
  - Last block: n = max(1, ceil(bytes/OUT_BYTES)).
- Word order: word k = block bits [OUT_WIDTH*(k+1)-1 : OUT_WIDTH*k], emitted LSB-first.
- Byte j of word k is valid iff k*OUT_BYTES + j < bytes. Invalid bytes output 0x00 with strobe 0.
- Zero-byte last block: exactly one word is emitted with data 0, strb 0, and out_last_o=1, so the consumer still sees end-of-message.
- out_last_o = held last flag && (word index == n-1).
- AXI-stream rule: while out_valid_o && !out_ready_i, out_data_o, out_strb_o and out_last_o are held stable.
- flush_i has priority over all handshakes. On the next edge: state=IDLE, out_valid_o=0, word index=0. No input block is captured in the flush cycle.
- Reset mid-operation behaves like flush_i, asynchronously.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_strb_o=0, out_last_o=0, state=IDLE, in_ready_o=1 (combinational from IDLE).
- Latency: block captured at edge N; first word valid in cycle N+1.
- Throughput: one word per cycle while out_ready_i=1. There is no bubble between consecutive blocks, so a full block occupies exactly WORDS cycles.
- Outputs are driven from registers, except in_ready_o.
- Word index counter width: $clog2(WORDS), minimum 1. It wraps to 0 on the final-word handshake.

## Structure
- Add to ascon_pack:
  - BLOCK_BYTES.
  - function byte_cnt_clamp(count, is_last) returning a CNT_W value.
- Sub-module ascon_byte_mask (combinational):
  - Inputs: word index, byte count.
  - Outputs: OUT_BYTES strobe vector and the matching zeroing mask.
  - Parametrised on OUT_WIDTH/BLOCK_WIDTH.
- The top level holds the FSM, the block register, the word counter and the output registers.

## Test plan
All scenarios use BLOCK_WIDTH=128, OUT_WIDTH=32.
- Full block, bytes 0x00..0x0F, last=0, out_ready_i=1 -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; strb 0xF; last=0; first word one cycle after capture.
- Last block, bytes=5, same data -> 2 words: 0x03020100 strb 0xF last 0, then 0x00000004 strb 0x1 last 1; then IDLE.
- Last block, bytes=0 -> 1 word: data 0x00000000, strb 0x0, last 1.
- Last block, bytes=20 -> clamped to 16; 4 words, all strb 0xF, last=1 on word 3 only.
- Random out_ready_i stalls over 3 back-to-back blocks:
  - Outputs stable during every stall; no word lost or duplicated.
  - With out_ready_i=1, block 2 word 0 follows block 1 word 3 with no gap.
- flush_i asserted after word 1 of a full block -> next cycle out_valid_o=0 and in_ready_o=1; a new block then emits from word 0.
- Repeat the abort with rst_i asynchronously mid-block -> all outputs at their reset values immediately.
